mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store front-end sitting directly upstream of the word-addressed data memory (1024 x 32, registered read, write-priority).
- Accepts byte-addressed load/store requests from the processor's MEM-stage control over a valid/ready handshake and converts byte addresses to word indices.
- Performs read-modify-write for byte/halfword stores, plus lane extraction and sign/zero extension for loads.
- Rejects misaligned and out-of-range accesses with a fault response and issues no memory access for them.

Parameters:
- DEPTH, 1024, number of 32-bit words in the attached data memory; valid word indices are 0..DEPTH-1.
- ADDR_W, 32, width of byte address and memory address bus.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; the request transfers when req_valid & req_ready at posedge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as a fault.
- req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and faults.
- resp_fault  out  1  qualified by resp_valid.
- mem_addr  out  ADDR_W  word index to memory (byte address >> 2).
- mem_wdata  out  32  data to memory data_in.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_rdata  in  32  memory data_out; valid the cycle after mem_rd.

Behaviour:
- Reset: state=IDLE; resp_valid=0; resp_rdata=0; resp_fault=0; mem_rd=0; mem_wr=0; mem_addr=0; mem_wdata=0.
- Accept: on acceptance, latch we/size/signed/addr/wdata. Word index = addr[ADDR_W-1:2], lane = addr[1:0].
- Fault (checked at accept): any of the following; next state RESP with fault=1; mem_rd and mem_wr never asserted.
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - word index >= DEPTH.
- States and transitions:
  - IDLE: request accepted -> fault ? RESP : (word store ? WRITE : READ).
  - READ: mem_rd=1, mem_addr=index -> WAIT.
  - WAIT: capture mem_rdata -> load ? RESP : MERGE_WRITE.
  - MERGE_WRITE / WRITE: mem_wr=1, mem_wdata = merged word (word store: req_wdata) -> RESP.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE.
- Latency (acceptance cycle = 0): resp_valid in cycle 3 for loads, 2 for word stores, 4 for sub-word stores, 1 for faults. Throughput is one request per latency+1 cycles; the next request is accepted in the cycle after RESP.
- Lane mapping: little-endian; byte k = bits [8k+7:8k], half h = bits [16h+15:16h].
  - Load extraction right-aligns the lane, then sign- or zero-extends to 32 bits.
  - Merge replaces only the addressed lane(s) with the low bits of wdata.
- Strobe invariants: mem_rd and mem_wr are never high together. Both are forced low while rst=1, so a write whose WRITE cycle coincides with reset is suppressed and memory is unchanged.
- Mid-operation reset: aborts the operation; no response is produced.
- Inputs while busy: req_valid and request fields are ignored while not in IDLE.

Optional Feature:
- Macro MEM_ACCESS_STATS_EN.
- Defined: adds 32-bit output ports stat_loads, stat_stores, stat_faults.
  - Each increments by 1 in the RESP cycle of the matching completion; faults count only in stat_faults.
  - All are cleared by rst and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mem_access_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, DEPTH default.
- Sub-module mem_lane_align (combinational): lane extract with sign/zero extend, plus lane merge for stores; instantiated once.

Test Plan:
- Memory preloaded mem[i]=i; LW addr 0x10 -> resp_valid in cycle 3, rdata=0x00000004, fault=0; mem_rd high exactly one cycle with mem_addr=4.
- SW 0xDEADBEEF @0x80, then:
  - LB signed @0x81 -> 0xFFFFFFBE;
  - LBU @0x83 -> 0x000000DE;
  - LH signed @0x82 -> 0xFFFFDEAD.
- After the above, SB 0xAA @0x80 -> response in cycle 4; then LW @0x80 -> 0xDEADBEAA. SH 0x1234 @0x82 then LW -> 0x1234BEAA.
- Faults, each responding in cycle 1 with fault=1, rdata=0 and no mem_rd/mem_wr: LW @0x82; LH @0x81; LW @0x1000 (index 1024); req_size=11.
- Assert rst during the WRITE cycle of SW 0x55 @0x40 -> mem_wr=0, no resp_valid; subsequent LW @0x40 -> 0x00000010.
- Hold req_valid high with two back-to-back LW requests -> second accepted the cycle after the first RESP; req_ready low in all other busy cycles.
- With MEM_ACCESS_STATS_EN defined, run 2 loads, 1 store, 1 fault -> counters read 2, 1, 1.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store front-end: access sizes, FSM states, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_access_pkg;

   localparam int DEPTH_DEFAULT  = 1024;
   localparam int ADDR_W_DEFAULT = 32;

   // Access size encodings as presented on req_size; 2'b11 is illegal.
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_READ        = 3'd1,
      ST_WAIT        = 3'd2,
      ST_MERGE_WRITE = 3'd3,
      ST_WRITE       = 3'd4,
      ST_RESP        = 3'd5
   } state_t;

   // True when the size code is illegal or the byte lane is not naturally aligned.
   function automatic logic size_lane_fault(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lane[0];
         SZ_WORD: bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane extraction with sign/zero extension for loads, and lane merge for sub-word stores.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        is_signed,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte / halfword out of the little-endian word.
   always_comb begin
      byte_sel = word[7:0];
      case (lane)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = lane[1] ? word[31:16] : word[15:0];
   end

   // Right-align the lane and extend to 32 bits.
   always_comb begin
      load_data = '0;
      case (size)
         SZ_BYTE: load_data = is_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
         SZ_HALF: load_data = is_signed ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
         SZ_WORD: load_data = word;
         default: load_data = '0;
      endcase
   end

   // Replace only the addressed lane(s) with the low bits of the store data.
   always_comb begin
      merged = word;
      case (size)
         SZ_BYTE: merged[{lane, 3'b000} +: 8]   = wdata[7:0];
         SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         SZ_WORD: merged = wdata;
         default: merged = word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end: byte-addressed requests -> word memory, RMW for sub-word stores (optional MEM_ACCESS_STATS_EN counters).
// Latency from accept: load 3, word store 2, sub-word store 4, fault 1 cycle to resp_valid.
// Backpressure: req_ready high only in IDLE; one request in flight, fields ignored while busy.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_fault,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [31:0]       mem_rdata
`ifdef MEM_ACCESS_STATS_EN
   ,
   output logic [31:0]       stat_loads,
   output logic [31:0]       stat_stores,
   output logic [31:0]       stat_faults
`endif
);

   localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

   state_t              state, next_state;
   logic                we_q, signed_q, fault_q;
   logic [1:0]          size_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [31:0]         rdata_q;
   logic                accept;
   logic                fault_in;
   logic [ADDR_W-1:0]   word_idx_q;
   logic [31:0]         load_data;
   logic [31:0]         merged;

   assign word_idx_q = {2'b00, addr_q[ADDR_W-1:2]};

   // Fault decode on the incoming request: bad size/alignment or word index past the memory.
   assign fault_in = size_lane_fault(req_size, req_addr[1:0]) ||
                     ({2'b00, req_addr[ADDR_W-1:2]} >= DEPTH_W);

   mem_lane_align u_align (
      .word      (rdata_q),
      .lane      (addr_q[1:0]),
      .size      (size_q),
      .is_signed (signed_q),
      .wdata     (wdata_q),
      .load_data (load_data),
      .merged    (merged)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // Latch the accepted request and capture the memory word one cycle after the read strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q     <= 1'b0;
         signed_q <= 1'b0;
         fault_q  <= 1'b0;
         size_q   <= SZ_BYTE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         if (accept) begin
            we_q     <= req_we;
            signed_q <= req_signed;
            fault_q  <= fault_in;
            size_q   <= req_size;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
         end
         if (state == ST_WAIT) rdata_q <= mem_rdata;
      end
   end

   // Next-state and output decode; strobes and responses are gated off while reset is held.
   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      accept     = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_fault = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            accept    = req_valid;
            if (req_valid) begin
               if (fault_in)                           next_state = ST_RESP;
               else if (req_we && (req_size == SZ_WORD)) next_state = ST_WRITE;
               else                                    next_state = ST_READ;
            end
         end
         ST_READ: begin
            mem_rd     = !rst;
            mem_addr   = word_idx_q;
            next_state = ST_WAIT;
         end
         ST_WAIT: begin
            next_state = we_q ? ST_MERGE_WRITE : ST_RESP;
         end
         ST_MERGE_WRITE, ST_WRITE: begin
            mem_wr     = !rst;
            mem_addr   = word_idx_q;
            mem_wdata  = merged;
            next_state = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = !rst;
            resp_fault = fault_q && !rst;
            resp_rdata = (!rst && !fault_q && !we_q) ? load_data : 32'd0;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

`ifdef MEM_ACCESS_STATS_EN
   // Completion counters, bumped in the RESP cycle; faults are counted only as faults.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_loads  <= '0;
         stat_stores <= '0;
         stat_faults <= '0;
      end else if (state == ST_RESP) begin
         if (fault_q)   stat_faults <= stat_faults + 32'd1;
         else if (we_q) stat_stores <= stat_stores + 32'd1;
         else           stat_loads  <= stat_loads + 32'd1;
      end
   end
`endif

endmodule
